dm_port_arbiter: RTL
====================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the byte-addressable data memory between two requesters: CPU load/store (port 0, cpu_*) and debug/DMA (port 1, dbg_*).
//  Arbitrates, latches one request, drives the memory for one cycle and returns read data, or an error for misaligned accesses.
//  Sits between the pipeline MEM stage / debug unit and the data memory; the memory side uses the DM's WE/MemDst/Addr/WData/IAddr/isu contract.
// PARAMETERS
//  AW  12  byte-address width
//  DW  32  data width
// PORTS
//  clk            input   1   clock, rising edge
//  reset          input   1   asynchronous, active-high reset
//  cpu_req/dbg_req           input  1   request; held with all fields stable until gnt
//  cpu_we/dbg_we             input  1   1=store, 0=load
//  cpu_size/dbg_size         input  2   0=byte, 1=half, 3=word, 2=illegal
//  cpu_isu/dbg_isu           input  1   load zero-extend (1) / sign-extend (0)
//  cpu_addr/dbg_addr         input  AW  byte address
//  cpu_wdata/dbg_wdata       input  DW  store data, LSB-aligned
//  cpu_pc/dbg_pc             input  32  instruction address, forwarded for store trace
//  cpu_gnt/dbg_gnt           output 1   1-cycle accept pulse
//  cpu_rvalid/dbg_rvalid     output 1   1-cycle response pulse
//  cpu_err/dbg_err           output 1   valid with rvalid: misaligned/illegal
//  cpu_rdata/dbg_rdata       output DW  load data, valid with rvalid
//  mem_we         output  1   memory write enable
//  mem_dst        output  2   memory size code (same encoding as *_size)
//  mem_isu        output  1   memory extension select
//  mem_addr       output  AW  memory address
//  mem_wdata      output  DW  memory write data
//  mem_iaddr      output  32  memory trace PC
//  mem_rdata      input   DW  memory combinational read data
// BEHAVIOUR
//  FSM: IDLE -> ISSUE -> RESP -> IDLE, one transaction per 3 cycles.
//  IDLE, cycle N, any req: pick the winner, assert its gnt combinationally in N, latch port id/we/size/isu/addr/wdata/pc at the end of N.
//  ISSUE, N+1: mem_* driven from the latch.
//   - mem_we = latched we & ~err.
//   - mem_rdata captured at the end of N+1.
//  RESP, N+2: winner's rvalid=1 with its rdata/err; the other port's outputs stay 0.
//  Response values:
//   - Loads: rdata = captured mem_rdata.
//   - Stores, and any err: rdata = 0.
//  Error rule:
//   - size=2 -> err.
//   - size=1 with addr[0]=1 -> err.
//   - size=3 with addr[1:0]!=0 -> err.
//   - An err access never writes memory.
//  Outside ISSUE, all mem_* outputs are 0; mem_we is high only in ISSUE.
//  A req seen in ISSUE/RESP is not granted; it waits for IDLE.
//  A port may raise a new req in its own RESP cycle; it is arbitrated in the next IDLE.
//  Reset value of every output is 0; state=IDLE; latch cleared; last_grant=1.
//  Reset mid-transaction aborts immediately: no rvalid; mem_we drops asynchronously with state.
//  Request dropped before gnt: ignored, no response.
// CONFIGURATION
//  DM_ARB_ROUND_ROBIN_EN
//   - Defined: on a simultaneous request, grant the port != last_grant; last_grant updates on every gnt.
//   - Undefined: fixed priority, cpu always wins a tie; last_grant is unused.
// TESTING
//  1. cpu word store addr=0x010, wdata=0xDEADBEEF, pc=0x3000 -> cpu_gnt@N; mem_we=1, mem_dst=3, mem_addr=0x010, mem_iaddr=0x3000 @N+1; cpu_rvalid=1, err=0, rdata=0 @N+2.
//  2. cpu lb addr=0x011, isu=0, mem_rdata=0xFFFFFF80 -> cpu_rdata=0xFFFFFF80, cpu_rvalid @N+2, mem_we=0 throughout.
//  3. dbg sh addr=0x013 -> dbg_err=1 @N+2, mem_we=0 @N+1; size=2 at any addr -> err=1.
//  4. cpu and dbg request together for 4 transactions:
//     - With RR_EN: grants cpu, dbg, cpu, dbg.
//     - Without RR_EN: cpu every time while cpu_req is held.
//  5. Assert reset during ISSUE of a store -> mem_we=0 immediately, no rvalid, state IDLE; next req is granted normally.
//  6. dbg_req raised while cpu is in ISSUE -> dbg_gnt only in the following IDLE (N+3), dbg_rvalid @N+5.

Source files
------------

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the two requester ports (cpu, dbg) and the data-memory side of dm_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory environment's view.
interface dm_port_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          cpu_req,   dbg_req;
    logic          cpu_we,    dbg_we;
    logic [1:0]    cpu_size,  dbg_size;
    logic          cpu_isu,   dbg_isu;
    logic [AW-1:0] cpu_addr,  dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic [31:0]   cpu_pc,    dbg_pc;
    logic          cpu_gnt,   dbg_gnt;
    logic          cpu_rvalid, dbg_rvalid;
    logic          cpu_err,   dbg_err;
    logic [DW-1:0] cpu_rdata, dbg_rdata;

    logic          mem_we;
    logic [1:0]    mem_dst;
    logic          mem_isu;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [31:0]   mem_iaddr;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_isu, cpu_addr, cpu_wdata, cpu_pc,
        input  dbg_req, dbg_we, dbg_size, dbg_isu, dbg_addr, dbg_wdata, dbg_pc,
        output cpu_gnt, cpu_rvalid, cpu_err, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
        output mem_we, mem_dst, mem_isu, mem_addr, mem_wdata, mem_iaddr,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_isu, cpu_addr, cpu_wdata, cpu_pc,
        output dbg_req, dbg_we, dbg_size, dbg_isu, dbg_addr, dbg_wdata, dbg_pc,
        input  cpu_gnt, cpu_rvalid, cpu_err, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
        input  mem_we, mem_dst, mem_isu, mem_addr, mem_wdata, mem_iaddr,
        output mem_rdata
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port (cpu/dbg) data-memory arbiter: IDLE -> ISSUE -> RESP, one access per 3 cycles.
// Define DM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed cpu priority.
module dm_port_arbiter #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input logic               clk,
    input logic               reset,
    dm_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          port_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic          isu_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [31:0]   pc_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;

    logic          take;
    logic          sel_dbg;
    logic          sel_we;
    logic [1:0]    sel_size;
    logic          sel_isu;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [31:0]   sel_pc;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = a[0];
            2'd3:    misaligned = (a != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

`ifdef DM_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     last_grant_q <= 1'b1;
        else if (take) last_grant_q <= sel_dbg;
    end

    // On a tie, the port that did not win last time goes first.
    assign sel_dbg = bus.dbg_req & (~bus.cpu_req | ~last_grant_q);
`else
    assign sel_dbg = bus.dbg_req & ~bus.cpu_req;
`endif

    assign take      = (state_q == IDLE) & (bus.cpu_req | bus.dbg_req);
    assign sel_we    = sel_dbg ? bus.dbg_we    : bus.cpu_we;
    assign sel_size  = sel_dbg ? bus.dbg_size  : bus.cpu_size;
    assign sel_isu   = sel_dbg ? bus.dbg_isu   : bus.cpu_isu;
    assign sel_addr  = sel_dbg ? bus.dbg_addr  : bus.cpu_addr;
    assign sel_wdata = sel_dbg ? bus.dbg_wdata : bus.cpu_wdata;
    assign sel_pc    = sel_dbg ? bus.dbg_pc    : bus.cpu_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            isu_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (take) begin
                port_q  <= sel_dbg;
                we_q    <= sel_we;
                size_q  <= sel_size;
                isu_q   <= sel_isu;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                pc_q    <= sel_pc;
                err_q   <= misaligned(sel_size, sel_addr[1:0]);
            end
            // Stores and faulting accesses return zero read data.
            if (state_q == ISSUE)
                rdata_q <= (we_q | err_q) ? '0 : bus.mem_rdata;
        end
    end

    always_comb begin
        bus.cpu_gnt    = 1'b0;
        bus.dbg_gnt    = 1'b0;
        bus.cpu_rvalid = 1'b0;
        bus.dbg_rvalid = 1'b0;
        bus.cpu_err    = 1'b0;
        bus.dbg_err    = 1'b0;
        bus.cpu_rdata  = '0;
        bus.dbg_rdata  = '0;
        bus.mem_we     = 1'b0;
        bus.mem_dst    = 2'd0;
        bus.mem_isu    = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_iaddr  = '0;
        case (state_q)
            IDLE: begin
                bus.cpu_gnt = take & ~sel_dbg;
                bus.dbg_gnt = take & sel_dbg;
            end
            ISSUE: begin
                bus.mem_we    = we_q & ~err_q;
                bus.mem_dst   = size_q;
                bus.mem_isu   = isu_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                bus.mem_iaddr = pc_q;
            end
            RESP: begin
                if (port_q) begin
                    bus.dbg_rvalid = 1'b1;
                    bus.dbg_err    = err_q;
                    bus.dbg_rdata  = rdata_q;
                end else begin
                    bus.cpu_rvalid = 1'b1;
                    bus.cpu_err    = err_q;
                    bus.cpu_rdata  = rdata_q;
                end
            end
            default: ;
        endcase
    end
endmodule
